// File: rtl/guard_recovery_pkg.sv
// Shared types for the guard recovery sequencer: FSM state encoding and counter widths.
package guard_recovery_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISOLATE  = 3'd1,
    ST_RESET    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_CLEAR    = 3'd4,
    ST_RELEASE  = 3'd5,
    ST_WAIT_ACK = 3'd6
  } recovery_state_e;

  localparam int unsigned DefCntWidth    = 16;
  localparam int unsigned DefRecCntWidth = 8;

  typedef logic [DefCntWidth-1:0]    cycle_cnt_t;
  typedef logic [DefRecCntWidth-1:0] rec_cnt_t;

endpackage

// File: rtl/guard_recovery_ctrl_delay_cnt.sv
// Loadable up-counter with sync clear and a terminal-match compare against a runtime limit.
module guard_delay_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [Width-1:0] ld_val_i,
  input  logic [Width-1:0] limit_i,
  output logic             match_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     cnt_q <= '0;
    else if (clr_i)  cnt_q <= '0;
    else if (ld_i)   cnt_q <= ld_val_i;
    else if (en_i)   cnt_q <= cnt_q + 1'b1;
  end

  assign match_o = (cnt_q == limit_i);

endmodule

// File: rtl/guard_recovery_ctrl.sv
// Guard recovery sequencer: isolate, reset pulse, settle, clear guards, release.
// Optional GUARD_RECOVERY_SW_ACK_EN holds isolation in WAIT_ACK until sw_ack_i.
module guard_recovery_ctrl
  import guard_recovery_pkg::*;
#(
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned RstCycles   = 16,
  parameter int unsigned HoldCycles  = 64,
  parameter int unsigned IsoTimeout  = 256,
  parameter int unsigned RecCntWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   wr_reset_req_i,
  input  logic                   rd_reset_req_i,
  input  logic                   isolated_i,
`ifdef GUARD_RECOVERY_SW_ACK_EN
  input  logic                   sw_ack_i,
`endif
  output logic                   isolate_o,
  output logic                   slv_rst_no,
  output logic                   reset_clear_o,
  output logic                   irq_o,
  output logic                   busy_o,
  output logic                   iso_timeout_o,
  output logic [RecCntWidth-1:0] recovery_cnt_o,
  output logic [2:0]             state_o
);

  // Terminal counts; HOLD with zero cycles still spends one pass-through cycle.
  localparam logic [CntWidth-1:0] IsoLim  = CntWidth'(IsoTimeout - 1);
  localparam logic [CntWidth-1:0] RstLim  = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] HoldLim = (HoldCycles == 0) ? '0 : CntWidth'(HoldCycles - 1);

  recovery_state_e       state_q, state_d;
  logic [CntWidth-1:0]   limit;
  logic                  cnt_match, tmo_set;
  logic                  isolate_d, slv_rst_n_d, clear_d, irq_d, busy_d;
  logic [RecCntWidth-1:0] rec_cnt_q, rec_cnt_d;
  logic                  isolate_q, slv_rst_n_q, clear_q, irq_q, busy_q, tmo_q;

  guard_delay_cnt #(.Width(CntWidth)) u_delay_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_d != state_q),
    .en_i     (state_q != ST_IDLE),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .limit_i  (limit),
    .match_o  (cnt_match)
  );

  always_comb begin
    case (state_q)
      ST_ISOLATE: limit = IsoLim;
      ST_RESET:   limit = RstLim;
      ST_HOLD:    limit = HoldLim;
      default:    limit = '0;
    endcase
  end

  // State register plus registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      isolate_q   <= 1'b0;
      slv_rst_n_q <= 1'b1;
      clear_q     <= 1'b0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      rec_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      isolate_q   <= isolate_d;
      slv_rst_n_q <= slv_rst_n_d;
      clear_q     <= clear_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_q | tmo_set;
      rec_cnt_q   <= rec_cnt_d;
    end
  end

  // Next-state logic; isolated_i beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    tmo_set = 1'b0;
    case (state_q)
      ST_IDLE:    if (enable_i && (wr_reset_req_i || rd_reset_req_i)) state_d = ST_ISOLATE;
      ST_ISOLATE: begin
        if (isolated_i) state_d = ST_RESET;
        else if (cnt_match) begin
          state_d = ST_RESET;
          tmo_set = 1'b1;
        end
      end
      ST_RESET:   if (cnt_match) state_d = ST_HOLD;
      ST_HOLD:    if (cnt_match) state_d = ST_CLEAR;
`ifdef GUARD_RECOVERY_SW_ACK_EN
      ST_CLEAR:    state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (sw_ack_i) state_d = ST_RELEASE;
`else
      ST_CLEAR:    state_d = ST_RELEASE;
`endif
      ST_RELEASE: if (!isolated_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_o.
  always_comb begin
    isolate_d   = state_d inside {ST_ISOLATE, ST_RESET, ST_HOLD, ST_CLEAR, ST_WAIT_ACK};
    slv_rst_n_d = (state_d != ST_RESET);
    clear_d     = (state_d == ST_CLEAR);
    irq_d       = (state_q == ST_IDLE) && (state_d == ST_ISOLATE);
    busy_d      = (state_d != ST_IDLE);
    rec_cnt_d   = rec_cnt_q;
    if (state_d == ST_CLEAR && state_q != ST_CLEAR && rec_cnt_q != '1)
      rec_cnt_d = rec_cnt_q + 1'b1;
  end

  assign isolate_o      = isolate_q;
  assign slv_rst_no     = slv_rst_n_q;
  assign reset_clear_o  = clear_q;
  assign irq_o          = irq_q;
  assign busy_o         = busy_q;
  assign iso_timeout_o  = tmo_q;
  assign recovery_cnt_o = rec_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_guard_recovery_ctrl.sv
// Randomized bench: two instances (default and boundary parameters) checked per cycle
// against a planned timeline of expected states built from the phase-length rules.
module tb_guard_recovery_ctrl;

  localparam int NCYC = 9000;
  localparam int RSTC [2] = '{16, 1};
  localparam int HOLDC[2] = '{64, 0};
  localparam int ISOT [2] = '{256, 8};
  localparam int MAXC [2] = '{255, 3};

  typedef struct {
    logic [2:0] st;
    bit         iso;
    bit         ack;
    bit         irq;
    bit         tmo;
  } ent_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic en [2], wr [2], rd [2], iso [2], ack [2];
  logic iso_o [2], srst_n [2], clr_o [2], irq_o [2], busy_o [2], tmo_o [2];
  logic [2:0] st [2];
  logic [7:0] rc0;
  logic [1:0] rc1;

  int n_cmp = 0, n_err = 0;
  ent_t pq [2][$];
  int mcnt [2];
  bit mtmo [2], en_hold [2];

  always #5 clk = ~clk;

  guard_recovery_ctrl u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(en[0]), .wr_reset_req_i(wr[0]),
    .rd_reset_req_i(rd[0]), .isolated_i(iso[0]),
`ifdef GUARD_RECOVERY_SW_ACK_EN
    .sw_ack_i(ack[0]),
`endif
    .isolate_o(iso_o[0]), .slv_rst_no(srst_n[0]), .reset_clear_o(clr_o[0]), .irq_o(irq_o[0]),
    .busy_o(busy_o[0]), .iso_timeout_o(tmo_o[0]), .recovery_cnt_o(rc0), .state_o(st[0])
  );

  guard_recovery_ctrl #(.RstCycles(1), .HoldCycles(0), .IsoTimeout(8), .RecCntWidth(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(en[1]), .wr_reset_req_i(wr[1]),
    .rd_reset_req_i(rd[1]), .isolated_i(iso[1]),
`ifdef GUARD_RECOVERY_SW_ACK_EN
    .sw_ack_i(ack[1]),
`endif
    .isolate_o(iso_o[1]), .slv_rst_no(srst_n[1]), .reset_clear_o(clr_o[1]), .irq_o(irq_o[1]),
    .busy_o(busy_o[1]), .iso_timeout_o(tmo_o[1]), .recovery_cnt_o(rc1), .state_o(st[1])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  function automatic ent_t mk(input int s, input bit i, input bit a, input bit q, input bit t);
    ent_t e;
    e.st = 3'(s); e.iso = i; e.ack = a; e.irq = q; e.tmo = t;
    return e;
  endfunction

  // Expected timeline for one recovery, given the isolated_i/sw_ack_i schedule chosen here.
  task automatic plan(input int k);
    int d, r, ilen, hlen;
    bit t;
    if (k == 0) begin
      case ($urandom_range(9))
        0:       d = ISOT[0] - 1;
        1:       d = ISOT[0] + 40;
        default: d = $urandom_range(20);
      endcase
    end else d = $urandom_range(12);
    t    = (d >= ISOT[k]);
    ilen = t ? ISOT[k] : d + 1;
    hlen = (HOLDC[k] == 0) ? 1 : HOLDC[k];
    for (int i = 0; i < ilen; i++)    pq[k].push_back(mk(1, i >= d, 0, i == 0, 0));
    for (int i = 0; i < RSTC[k]; i++) pq[k].push_back(mk(2, !t, 0, 0, t && i == 0));
    for (int i = 0; i < hlen; i++)    pq[k].push_back(mk(3, !t, 0, 0, 0));
    pq[k].push_back(mk(4, !t, 0, 0, 0));
`ifdef GUARD_RECOVERY_SW_ACK_EN
    begin
      int a;
      a = ($urandom_range(3) == 0) ? 100 + $urandom_range(20) : $urandom_range(5);
      for (int i = 0; i <= a; i++) pq[k].push_back(mk(6, !t, i == a, 0, 0));
    end
`endif
    r = t ? 0 : $urandom_range(4);
    for (int i = 0; i <= r; i++) pq[k].push_back(mk(5, i < r, 0, 0, 0));
  endtask

  task automatic check_outs(input int k, input ent_t e);
    logic [31:0] rc;
    bit isl;
    rc  = (k == 0) ? 32'(rc0) : 32'(rc1);
    isl = (e.st inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6});
    chk($sformatf("d%0d.state", k),     st[k],     e.st);
    chk($sformatf("d%0d.isolate", k),   iso_o[k],  isl);
    chk($sformatf("d%0d.slv_rst_n", k), srst_n[k], e.st != 3'd2);
    chk($sformatf("d%0d.clear", k),     clr_o[k],  e.st == 3'd4);
    chk($sformatf("d%0d.irq", k),       irq_o[k],  e.irq);
    chk($sformatf("d%0d.busy", k),      busy_o[k], e.st != 3'd0);
    chk($sformatf("d%0d.timeout", k),   tmo_o[k],  mtmo[k]);
    chk($sformatf("d%0d.rec_cnt", k),   rc,        mcnt[k]);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      pq[k].delete();
      mcnt[k] = 0; mtmo[k] = 0;
      en[k] = 0; wr[k] = 0; rd[k] = 0; iso[k] = 0; ack[k] = 0;
      en_hold[k] = 1;
    end
  endtask

  initial begin
    ent_t e, cur0;
    bit idle, in_rst, ar_done;
    in_rst = 0; ar_done = 0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_outs(k, mk(0, 0, 0, 0, 0));
    rst_ni = 1'b1;

    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      if (in_rst) begin
        rst_ni = 1'b1;
        in_rst = 0;
      end
      for (int k = 0; k < 2; k++) begin
        idle = (pq[k].size() == 0);
        e = idle ? mk(0, 0, 0, 0, 0) : pq[k].pop_front();
        if (e.st == 3'd4 && mcnt[k] < MAXC[k]) mcnt[k]++;
        if (e.tmo) mtmo[k] = 1;
        check_outs(k, e);
        if (k == 0) cur0 = e;
        // Guard drops its latched request once it has seen reset_clear.
        if (e.st == 3'd4) begin wr[k] = 0; rd[k] = 0; end
        else if (!wr[k] && !rd[k] && $urandom_range(7) == 0) begin
          if ($urandom_range(1) == 0) wr[k] = 1; else rd[k] = 1;
        end
        if ($urandom_range(15) == 0) en_hold[k] = !en_hold[k];
        en[k]  = en_hold[k];
        iso[k] = e.iso;
        ack[k] = e.ack;
        if (idle && en[k] && (wr[k] || rd[k])) plan(k);
      end
      if (!ar_done && n > 4000 && cur0.st == 3'd2) begin
        ar_done = 1;
        #2 rst_ni = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("ar%0d.state", k),     st[k],     0);
          chk($sformatf("ar%0d.slv_rst_n", k), srst_n[k], 1);
          chk($sformatf("ar%0d.isolate", k),   iso_o[k],  0);
          chk($sformatf("ar%0d.busy", k),      busy_o[k], 0);
        end
        clear_model();
        in_rst = 1;
      end
    end
    chk("async_reset_reached", ar_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
